// File: rtl/mem_pkg.sv
// Shared types for mem_responder: access-size encodings, FSM states and lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int unsigned LANES = 4;

    function automatic logic [LANES-1:0] lane_mask(input size_e sz);
        case (sz)
            SZ_BYTE: lane_mask = 4'b0001;
            SZ_HALF: lane_mask = 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] low_addr);
        case (sz)
            SZ_HALF: misaligned = low_addr[0];
            SZ_WORD: misaligned = (low_addr != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with four independent lanes: per-lane address, write enable,
// write byte and asynchronous read byte. Contents are never reset.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                         clk,
    input  logic [LANES-1:0][ADDR_W-1:0] lane_addr,
    input  logic [LANES-1:0]             lane_we,
    input  logic [LANES-1:0][7:0]        lane_wdata,
    output logic [LANES-1:0][7:0]        lane_rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                mem[lane_addr[i]] <= lane_wdata[i];
            end
        end
    end

    always_comb begin
        lane_rdata = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_rdata[i] = mem[lane_addr[i]];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed LATENCY wait states and byte-lane storage.
// Optional macro MEM_RESPONDER_ALIGN_CHECK_EN faults misaligned halfword/word accesses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       accept;

    logic              we_q;
    size_e             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic                         fault;
    logic [LANES-1:0]             mask;
    logic [LANES-1:0][ADDR_W-1:0] lane_addr;
    logic [LANES-1:0]             lane_we;
    logic [LANES-1:0][7:0]        lane_wdata;
    logic [LANES-1:0][7:0]        lane_rdata;

    // Upper address bits are deliberately dropped so the space wraps.
    if (ADDR_W < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[31:ADDR_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= we;
                size_q  <= size_e'(size);
                addr_q  <= addr[ADDR_W-1:0];
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    cnt_nxt   = 4'(LATENCY);
                    state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign fault = (size_q == SZ_RSVD) || misaligned(size_q, addr_q[1:0]);
`else
    assign fault = (size_q == SZ_RSVD);
`endif

    assign mask       = lane_mask(size_q);
    assign lane_wdata = wdata_q;

    always_comb begin
        lane_addr = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_addr[i] = addr_q + ADDR_W'(i);
        end
    end

    // Writes commit on the edge that leaves RESP, so an async reset in RESP drops them.
    always_comb begin
        ready   = (state == IDLE);
        rvalid  = (state == RESP);
        err     = 1'b0;
        rdata   = '0;
        lane_we = '0;
        if (state == RESP) begin
            err = fault;
            if (!fault) begin
                if (we_q) begin
                    lane_we = mask;
                end else begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (mask[i]) begin
                            rdata[8*i +: 8] = lane_rdata[i];
                        end
                    end
                end
            end
        end
    end

    mem_byte_array #(
        .ADDR_W(ADDR_W)
    ) u_storage (
        .clk       (clk),
        .lane_addr (lane_addr),
        .lane_we   (lane_we),
        .lane_wdata(lane_wdata),
        .lane_rdata(lane_rdata)
    );

endmodule
